// File: rtl/cache_controller.sv
// Direct-mapped, one-word-line, write-through/write-allocate controller in front of a registered data array.
// Load hit: ready 3 cycles after accept. Miss/store: ready the cycle after mem_ack. Requests are taken only in IDLE.
module cache_controller #(
  parameter int INDEX_W    = 10,
  parameter int DATA_W     = 32,
  parameter int CPU_ADDR_W = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  gen_reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [CPU_ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_ready,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  flush,
  output logic                  cache_we,
  output logic                  cache_re,
  output logic [INDEX_W-1:0]    cache_adress,
  output logic [DATA_W-1:0]     cache_data_in,
  input  logic [DATA_W-1:0]     cache_data_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [CPU_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  localparam int TAG_W = CPU_ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RD_WAIT, MEM_RD, MEM_WR, RESP
  } state_t;

  state_t                  state, state_nxt;
  logic [CPU_ADDR_W-1:0]   req_addr;
  logic                    req_we;
  logic [DATA_W-1:0]       req_wdata;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem [LINES];
  logic [INDEX_W-1:0]      req_index;
  logic [TAG_W-1:0]        req_tag;
  logic                    hit;
  logic                    fill;
  logic                    hit_inc;
  logic                    miss_inc;
  logic [CNT_W-1:0]        hit_cnt;
  logic [CNT_W-1:0]        miss_cnt;

  assign req_index  = req_addr[INDEX_W-1:0];
  assign req_tag    = req_addr[CPU_ADDR_W-1:INDEX_W];
  assign hit        = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;

  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      valid     <= '0;
      cpu_rdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && !flush && cpu_req) begin
        req_addr  <= cpu_addr;
        req_we    <= cpu_we;
        req_wdata <= cpu_wdata;
      end
      // Fills happen only outside IDLE, so flush never collides with a valid set.
      if (state == IDLE && flush)
        valid <= '0;
      else if (fill)
        valid[req_index] <= 1'b1;
      if (state == RD_WAIT)
        cpu_rdata <= cache_data_out;
      else if (state == MEM_RD && mem_ack)
        cpu_rdata <= mem_rdata;
      if (hit_inc && hit_cnt != '1)
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss_inc && miss_cnt != '1)
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fill)
      tag_mem[req_index] <= req_tag;
  end

  always_comb begin
    state_nxt     = state;
    cpu_ready     = 1'b0;
    cache_we      = 1'b0;
    cache_re      = 1'b0;
    cache_adress  = '0;
    cache_data_in = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    fill          = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && cpu_req)
          state_nxt = LOOKUP;
      end
      LOOKUP: begin
        hit_inc  = hit;
        miss_inc = !hit;
        if (req_we) begin
          cache_we      = 1'b1;
          cache_adress  = req_index;
          cache_data_in = req_wdata;
          fill          = 1'b1;
          mem_req       = 1'b1;
          mem_we        = 1'b1;
          mem_addr      = req_addr;
          mem_wdata     = req_wdata;
          state_nxt     = MEM_WR;
        end else if (hit) begin
          cache_re     = 1'b1;
          cache_adress = req_index;
          state_nxt    = RD_WAIT;
        end else begin
          mem_req   = 1'b1;
          mem_addr  = req_addr;
          state_nxt = MEM_RD;
        end
      end
      RD_WAIT: state_nxt = RESP;
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (mem_ack) begin
          cache_we      = 1'b1;
          cache_adress  = req_index;
          cache_data_in = mem_rdata;
          fill          = 1'b1;
          state_nxt     = RESP;
        end
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        if (mem_ack)
          state_nxt = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
